alu_seq: RTL and testbench

//   Parametrised, registered ALU for the pipelined CPU EX stage. Single-cycle
//   ops take one clock; MUL is an iterative shift-add multiplier taking WIDTH

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_mul_iter.sv | 70 +++++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the
// combinational result function used for every single-cycle operation.
package alu_pkg;

  // Widest datapath the single-cycle result function supports.
  localparam int ALU_MAX_W = 64;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SRAI = 4'b0111;
  localparam logic [3:0] OP_LSW  = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_NOP  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // Result of a single-cycle op on operands already widened to ALU_MAX_W.
  // Operand A must arrive sign-extended so that SRAI fills with the sign of
  // the narrow operand; the caller keeps only the low WIDTH bits. MUL, BEQ,
  // NOP and undefined codes all give zero here.
  function automatic logic [ALU_MAX_W-1:0] alu_single_result(
    input logic [3:0]           op,
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b,
    input logic [5:0]           shamt
  );
    logic [ALU_MAX_W-1:0] res_s;
    res_s = {ALU_MAX_W{1'b0}};
    case (op)
      OP_AND:                 res_s = a & b;
      OP_XOR:                 res_s = a ^ b;
      OP_OR:                  res_s = a | b;
      OP_SLL:                 res_s = a << shamt;
      OP_SRAI:                res_s = $signed(a) >>> shamt;
      OP_ADD, OP_ADDI, OP_LSW: res_s = a + b;
      OP_SUB:                 res_s = a - b;
      default:                res_s = {ALU_MAX_W{1'b0}};
    endcase
    return res_s;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock. Only the low
// WIDTH bits of the product are kept, which are correct for signed operands.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               ET_ON    = (EARLY_TERM != 0);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplr_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             last_s;
  logic             skip_s;

  // "done" flags the edge on which the product becomes final, so the caller
  // can step to its result-write state on that same edge. A zero multiplier
  // under early termination is final as soon as it is loaded.
  always_comb begin
    last_s = (cnt_r == LAST_CNT) ||
             (ET_ON && (mplr_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}));
    skip_s = ET_ON && (b == {WIDTH{1'b0}});
    done   = (go && skip_s) || (run_r && last_s);
  end

  assign product = acc_r;

  // Load operands on go, then run one shift-add step per clock until the last.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_r <= {WIDTH{1'b0}};
      mplr_r  <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      run_r   <= 1'b0;
    end else if (go) begin
      mcand_r <= a;
      mplr_r  <= b;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      run_r   <= !skip_s;
    end else if (run_r) begin
      if (mplr_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r <= {mcand_r[WIDTH-2:0], 1'b0};
      mplr_r  <= {1'b0, mplr_r[WIDTH-1:1]};
      cnt_r   <= cnt_r + CNT_ONE;
      if (last_s) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU. Single-cycle ops answer on the next edge; MUL runs
// in alu_mul_iter while busy_o stalls the pipeline, then one DONE cycle
// publishes the product.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e           state_r;
  alu_state_e           state_n_s;
  logic                 busy_r;
  logic                 busy_n_s;
  logic                 valid_r;
  logic                 valid_n_s;
  logic [WIDTH-1:0]     data_r;
  logic [WIDTH-1:0]     data_n_s;
  logic                 zero_r;
  logic                 zero_n_s;
  logic                 mul_go_s;
  logic                 mul_done_s;
  logic [WIDTH-1:0]     mul_prod_s;
  logic [ALU_MAX_W-1:0] a_ext_s;
  logic [ALU_MAX_W-1:0] b_ext_s;
  logic [5:0]           shamt_s;
  logic [ALU_MAX_W-1:0] single_s;
  logic [WIDTH-1:0]     single_res_s;
  logic                 unused_hi_s;

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .EARLY_TERM (EARLY_TERM)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .go      (mul_go_s),
    .a       (data1_i),
    .b       (data2_i),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Single-cycle result: widen operands, evaluate, keep the low WIDTH bits.
  // Shift amounts use only the low log2(WIDTH) bits of operand B.
  always_comb begin
    a_ext_s      = ALU_MAX_W'(signed'(data1_i));
    b_ext_s      = ALU_MAX_W'(data2_i);
    shamt_s      = 6'(data2_i[SH_W-1:0]);
    single_s     = alu_single_result(ALUCtrl_i, a_ext_s, b_ext_s, shamt_s);
    single_res_s = single_s[WIDTH-1:0];
    unused_hi_s  = ^single_s;
  end

  // Top FSM and next values of the registered outputs. Only IDLE accepts
  // start_i; MUL and DONE ignore it without queueing.
  always_comb begin
    state_n_s = state_r;
    busy_n_s  = busy_r;
    valid_n_s = 1'b0;
    data_n_s  = data_r;
    zero_n_s  = zero_r;
    mul_go_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mul_go_s = 1'b1;
            busy_n_s = 1'b1;
            if (mul_done_s) begin
              state_n_s = ST_DONE;
            end else begin
              state_n_s = ST_MUL;
            end
          end else begin
            data_n_s  = single_res_s;
            zero_n_s  = (single_res_s == {WIDTH{1'b0}});
            valid_n_s = 1'b1;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_MUL;
        end
      end
      ST_DONE: begin
        data_n_s  = mul_prod_s;
        zero_n_s  = (mul_prod_s == {WIDTH{1'b0}});
        valid_n_s = 1'b1;
        busy_n_s  = 1'b0;
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
        busy_n_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      zero_r  <= 1'b1;
    end else begin
      state_r <= state_n_s;
      busy_r  <= busy_n_s;
      valid_r <= valid_n_s;
      data_r  <= data_n_s;
      zero_r  <= zero_n_s;
    end
  end

  assign busy_o  = busy_r;
  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign Zero_o  = zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (32-bit, 32-bit early-terminating, 8-bit)
// checked every cycle against a cycle-level behavioural model, plus directed
// cases with hand-computed expectations.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic [3:0]  op_v    [3];
  logic [63:0] a_v     [3];
  logic [63:0] b_v     [3];
  logic        busy_v  [3];
  logic        valid_v [3];
  logic        zero_v  [3];
  logic [63:0] dout_v  [3];
  logic [31:0] d0_w, d1_w;
  logic [7:0]  d2_w;

  int checks = 0;
  int errors = 0;

  int          w_t  [3] = '{32, 32, 8};
  int          et_t [3] = '{0, 1, 0};

  // model state
  int          rem    [3];
  logic [63:0] pend   [3];
  logic [63:0] e_data [3];
  logic        e_valid[3];
  logic        e_busy [3];
  logic        e_zero [3];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .EARLY_TERM(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .ALUCtrl_i(op_v[0]),
    .data1_i(a_v[0][31:0]), .data2_i(b_v[0][31:0]), .busy_o(busy_v[0]),
    .valid_o(valid_v[0]), .data_o(d0_w), .Zero_o(zero_v[0]));
  alu_seq #(.WIDTH(32), .EARLY_TERM(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .ALUCtrl_i(op_v[1]),
    .data1_i(a_v[1][31:0]), .data2_i(b_v[1][31:0]), .busy_o(busy_v[1]),
    .valid_o(valid_v[1]), .data_o(d1_w), .Zero_o(zero_v[1]));
  alu_seq #(.WIDTH(8), .EARLY_TERM(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[2]), .ALUCtrl_i(op_v[2]),
    .data1_i(a_v[2][7:0]), .data2_i(b_v[2][7:0]), .busy_o(busy_v[2]),
    .valid_o(valid_v[2]), .data_o(d2_w), .Zero_o(zero_v[2]));

  assign dout_v[0] = {32'd0, d0_w};
  assign dout_v[1] = {32'd0, d1_w};
  assign dout_v[2] = {56'd0, d2_w};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference result of any op, from the arithmetic definitions.
  function automatic logic [63:0] ref_calc(input int w, input logic [3:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, am, bm, r, sa;
    int lg, sh;
    m  = wmask(w);
    am = a & m;
    bm = b & m;
    lg = 0;
    while ((1 << lg) < w) lg++;
    sh = int'(bm & ((64'd1 << lg) - 64'd1));
    sa = am[w-1] ? (am | ~m) : am;
    case (op)
      4'd0:               r = am & bm;
      4'd1:               r = am ^ bm;
      4'd2:               r = am << sh;
      4'd3, 4'd6, 4'd8:   r = am + bm;
      4'd4:               r = am - bm;
      4'd5:               r = am * bm;
      4'd7:               r = 64'($signed(sa) >>> sh);
      4'd10:              r = am | bm;
      default:            r = 64'd0;
    endcase
    return r & m;
  endfunction

  // Cycles from start to valid for a multiply.
  function automatic int mul_lat(input int w, input int et, input logic [63:0] b);
    logic [63:0] bm;
    int hi;
    bm = b & wmask(w);
    if (et == 0) return w + 2;
    if (bm == 64'd0) return 2;
    hi = 0;
    for (int i = 0; i < w; i++) if (bm[i]) hi = i;
    return hi + 3;
  endfunction

  // Per-cycle comparison against the model, then model advance for the next edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          rem[d] = 0; e_valid[d] = 1'b0; e_busy[d] = 1'b0;
          e_data[d] = 64'd0; e_zero[d] = 1'b1; pend[d] = 64'd0;
        end
        chk($sformatf("valid[%0d]", d), 64'(valid_v[d]), 64'(e_valid[d]));
        chk($sformatf("busy[%0d]", d),  64'(busy_v[d]),  64'(e_busy[d]));
        chk($sformatf("data[%0d]", d),  dout_v[d],       e_data[d]);
        chk($sformatf("zero[%0d]", d),  64'(zero_v[d]),  64'(e_zero[d]));
        if (!rst) begin
          if (rem[d] > 0) begin
            rem[d]--;
            if (rem[d] == 0) begin
              e_valid[d] = 1'b1; e_data[d] = pend[d];
              e_zero[d] = (pend[d] == 64'd0); e_busy[d] = 1'b0;
            end else begin
              e_valid[d] = 1'b0;
            end
          end else if (start_v[d]) begin
            if (op_v[d] == 4'd5) begin
              pend[d] = ref_calc(w_t[d], op_v[d], a_v[d], b_v[d]);
              rem[d] = mul_lat(w_t[d], et_t[d], b_v[d]) - 1;
              e_busy[d] = 1'b1; e_valid[d] = 1'b0;
            end else begin
              e_data[d] = ref_calc(w_t[d], op_v[d], a_v[d], b_v[d]);
              e_zero[d] = (e_data[d] == 64'd0);
              e_valid[d] = 1'b1; e_busy[d] = 1'b0;
            end
          end else begin
            e_valid[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int d, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    start_v[d] = 1'b1; op_v[d] = op; a_v[d] = a; b_v[d] = b;
    @(posedge clk); #1;
    start_v[d] = 1'b0; a_v[d] = {$urandom, $urandom}; b_v[d] = {$urandom, $urandom};
  endtask

  // Counts negedges until valid (bounded); also reports busy at the first one.
  task automatic wait_valid(input int d, input int bound, output int n, output logic busy1);
    n = 0;
    busy1 = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) busy1 = busy_v[d];
    end while (!valid_v[d] && n < bound);
  endtask

  int   n;
  logic bz;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0; op_v[d] = 4'd0; a_v[d] = 64'd0; b_v[d] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // back-to-back ADD, SUB, SRAI on the 32-bit instance
    @(posedge clk); #1;
    start_v[0] = 1'b1; op_v[0] = 4'd3; a_v[0] = 64'd7; b_v[0] = 64'hFFFF_FFFF_FFFF_FFF9;
    @(negedge clk);
    @(posedge clk); #1;
    op_v[0] = 4'd4; a_v[0] = 64'd5; b_v[0] = 64'd9;
    @(negedge clk);
    chk("b2b_add_valid", 64'(valid_v[0]), 64'd1);
    chk("b2b_add_data", dout_v[0], 64'd0);
    chk("b2b_add_zero", 64'(zero_v[0]), 64'd1);
    @(posedge clk); #1;
    op_v[0] = 4'd7; a_v[0] = 64'h8000_0000; b_v[0] = 64'd4;
    @(negedge clk);
    chk("b2b_sub_valid", 64'(valid_v[0]), 64'd1);
    chk("b2b_sub_data", dout_v[0], 64'hFFFF_FFFC);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("b2b_srai_valid", 64'(valid_v[0]), 64'd1);
    chk("b2b_srai_data", dout_v[0], 64'hF800_0000);

    // MUL -3*7, full-length iteration
    issue(0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
    wait_valid(0, 100, n, bz);
    chk("mul_busy", 64'(bz), 64'd1);
    chk("mul_latency", 64'(n), 64'd34);
    chk("mul_data", dout_v[0], 64'hFFFF_FFEB);
    chk("mul_zero", 64'(zero_v[0]), 64'd0);

    // ADD held while a MUL runs: ignored until the cycle after DONE
    @(posedge clk); #1;
    start_v[0] = 1'b1; op_v[0] = 4'd5; a_v[0] = 64'd6; b_v[0] = 64'd7;
    @(posedge clk); #1;
    op_v[0] = 4'd3; a_v[0] = 64'd1; b_v[0] = 64'd1;
    wait_valid(0, 100, n, bz);
    chk("hold_mul_latency", 64'(n), 64'd34);
    chk("hold_mul_data", dout_v[0], 64'd42);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("hold_add_valid", 64'(valid_v[0]), 64'd1);
    chk("hold_add_data", dout_v[0], 64'd2);

    // reset in the middle of a multiply
    issue(0, 4'd5, 64'd100, 64'd200);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_valid", 64'(valid_v[0]), 64'd0);
    chk("rst_data", dout_v[0], 64'd0);
    chk("rst_zero", 64'(zero_v[0]), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // early termination
    issue(1, 4'd5, 64'd12345, 64'd1);
    wait_valid(1, 100, n, bz);
    chk("et_mul1_latency", 64'(n), 64'd3);
    chk("et_mul1_data", dout_v[1], 64'd12345);
    issue(1, 4'd5, 64'd987, 64'd0);
    wait_valid(1, 100, n, bz);
    chk("et_mul0_latency", 64'(n), 64'd2);
    chk("et_mul0_data", dout_v[1], 64'd0);
    chk("et_mul0_zero", 64'(zero_v[1]), 64'd1);

    // 8-bit instance: shift amount uses 3 bits; undefined opcode
    issue(2, 4'd2, 64'h01, 64'h0B);
    wait_valid(2, 10, n, bz);
    chk("w8_sll_data", dout_v[2], 64'h08);
    chk("w8_sll_zero", 64'(zero_v[2]), 64'd0);
    issue(2, 4'hF, 64'h55, 64'h33);
    wait_valid(2, 10, n, bz);
    chk("w8_undef_data", dout_v[2], 64'd0);
    chk("w8_undef_zero", 64'(zero_v[2]), 64'd1);

    // random traffic on all instances
    repeat (3000) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        start_v[d] = 1'($urandom % 2);
        op_v[d] = 4'($urandom_range(0, 15));
        if ($urandom % 4 == 0) op_v[d] = 4'd5;
        a_v[d] = {$urandom, $urandom};
        case ($urandom % 4)
          0: b_v[d] = {$urandom, $urandom};
          1: b_v[d] = 64'($urandom % 4);
          2: b_v[d] = 64'd0;
          default: b_v[d] = 64'($urandom) >> $urandom_range(0, 31);
        endcase
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
